// File: rtl/ram_dump_if.sv
// UART, RAM read port and status signals of the RAM dump engine.
// master: dump engine side; slave: UART/RAM/host side.
interface ram_dump_if;
  logic        trigger;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        tx_done;
  logic [7:0]  tx_data;
  logic        transmit;
  logic [15:0] ram_addr;
  logic [7:0]  ram_rdata;
  logic        dumping;
  logic        done;
  logic        timeout;
  logic [15:0] err_count;

  modport master (
    input  trigger, rx_data, rx_done, tx_done, ram_rdata,
    output tx_data, transmit, ram_addr, dumping, done, timeout, err_count
  );

  modport slave (
    output trigger, rx_data, rx_done, tx_done, ram_rdata,
    input  tx_data, transmit, ram_addr, dumping, done, timeout, err_count
  );
endinterface

// File: rtl/ram_dump.sv
// Walks RAM 0..top, sends each byte over the UART and counts echo mismatches; first transmit 2 clocks after trigger.
// One byte in flight: waits for tx_done then the host echo, aborting after TIMEOUT_CYCLES clocks without one.
module ram_dump #(
  parameter int ADDR_BITS      = 10,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  ram_dump_if.master bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LATCH,
    S_WAIT_TX,
    S_WAIT_ACK,
    S_NEXT,
    S_DONE
  } state_t;

  state_t               state;
  logic [ADDR_BITS-1:0] addr;
  logic [7:0]           tx_data_q;
  logic                 transmit_q;
  logic                 dumping_q;
  logic                 done_q;
  logic                 timeout_q;
  logic [15:0]          err_q;
  logic [TW-1:0]        to_cnt;
  logic [7:0]           ack_dat;
  logic                 ack_vld;

  // An echo that arrived while the byte was still shifting out wins over a new rx_done.
  logic       echo_vld;
  logic [7:0] echo_dat;

  always_comb begin
    echo_vld = ack_vld | bus.rx_done;
    echo_dat = ack_vld ? ack_dat : bus.rx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      addr       <= '0;
      tx_data_q  <= '0;
      transmit_q <= 1'b0;
      dumping_q  <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      err_q      <= '0;
      to_cnt     <= '0;
      ack_dat    <= '0;
      ack_vld    <= 1'b0;
    end else if (bus.trigger) begin
      state      <= S_READ;
      addr       <= '0;
      err_q      <= '0;
      dumping_q  <= 1'b1;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      transmit_q <= 1'b0;
      ack_vld    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state <= S_IDLE;
        end

        S_READ: begin
          state <= S_LATCH;
        end

        S_LATCH: begin
          tx_data_q  <= bus.ram_rdata;
          transmit_q <= 1'b1;
          state      <= S_WAIT_TX;
        end

        S_WAIT_TX: begin
          transmit_q <= 1'b0;
          if (bus.rx_done) begin
            ack_dat <= bus.rx_data;
            ack_vld <= 1'b1;
          end
          if (bus.tx_done) begin
            to_cnt <= '0;
            state  <= S_WAIT_ACK;
          end
        end

        S_WAIT_ACK: begin
          if (echo_vld) begin
            if ((echo_dat != tx_data_q) && (err_q != 16'hFFFF)) begin
              err_q <= err_q + 16'd1;
            end
            ack_vld <= 1'b0;
            state   <= S_NEXT;
          end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            // Abort reports completion on the same edge so the host sees done with timeout.
            timeout_q <= 1'b1;
            dumping_q <= 1'b0;
            done_q    <= 1'b1;
            state     <= S_DONE;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end

        S_NEXT: begin
          if (&addr) begin
            state <= S_DONE;
          end else begin
            addr  <= addr + ADDR_BITS'(1);
            state <= S_READ;
          end
        end

        S_DONE: begin
          dumping_q <= 1'b0;
          done_q    <= 1'b1;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.tx_data   = tx_data_q;
  assign bus.transmit  = transmit_q;
  assign bus.ram_addr  = 16'(addr);
  assign bus.dumping   = dumping_q;
  assign bus.done      = done_q;
  assign bus.timeout   = timeout_q;
  assign bus.err_count = err_q;

endmodule

// File: tb/tb_ram_dump.sv
// Randomized bench for ram_dump: host/UART/RAM model drives stimulus, a monitor checks transmits and dump results.
module tb_ram_dump;
  localparam int AB = 3;
  localparam int TO = 50;
  localparam int NB = 1 << AB;

  logic clk       = 1'b0;
  logic rst_main  = 1'b1;
  logic rst_drv   = 1'b0;
  logic main_trig = 1'b0;
  logic drv_trig  = 1'b0;
  logic rst;

  assign rst = rst_main | rst_drv;

  ram_dump_if bus ();
  assign bus.trigger = main_trig | drv_trig;

  ram_dump #(.ADDR_BITS(AB), .TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [NB];
  always @(posedge clk) bus.ram_rdata <= mem[bus.ram_addr[AB-1:0]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         lat;
    int         off;
    bit         silent;
    bit         retrig;
    bit         rst_mid;
    bit         last;
    logic [7:0] echo;
  } step_t;

  typedef struct {
    logic [15:0] err;
    bit          tmo;
    logic [15:0] addr;
  } status_t;

  step_t      plan[$];
  logic [7:0] exp_bytes[$];
  int         exp_tx_cyc[$];
  int         exp_done_cyc[$];
  status_t    exp_status[$];
  bit         drv_busy = 1'b0;

  int checks   = 0;
  int failures = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endfunction

  // Monitor: every transmit pops the next expected byte and issue cycle; every done rise pops a dump result.
  logic prev_tx   = 1'b0;
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_tx   = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (bus.transmit) begin
        check("transmit_width", 64'(prev_tx), 64'(0));
        if (exp_bytes.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_transmit actual=0x%0h required=none", bus.tx_data);
        end else begin
          check("tx_data", 64'(bus.tx_data), 64'(exp_bytes.pop_front()));
          check("ram_addr_upper", 64'(bus.ram_addr[15:AB]), 64'(0));
          if (exp_tx_cyc.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL transmit_cycle actual=%0d required=none", cyc);
          end else begin
            check("transmit_cycle", 64'(cyc), 64'(exp_tx_cyc.pop_front()));
          end
        end
      end
      if (bus.done && !prev_done) begin
        if (exp_status.size() == 0 || exp_done_cyc.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=1 required=0 cycle=%0d", cyc);
        end else begin
          status_t st;
          st = exp_status.pop_front();
          check("done_err_count", 64'(bus.err_count), 64'(st.err));
          check("done_timeout", 64'(bus.timeout), 64'(st.tmo));
          check("done_ram_addr", 64'(bus.ram_addr), 64'(st.addr));
          check("done_dumping", 64'(bus.dumping), 64'(0));
          check("done_cycle", 64'(cyc), 64'(exp_done_cyc.pop_front()));
        end
      end
      prev_tx   = bus.transmit;
      prev_done = bus.done;
    end
  end

  // Host/UART model: per transmitted byte, pulse tx_done after lat clocks and echo at lat+off.
  initial begin
    step_t s;
    int c2, r, n, a;
    bus.tx_done = 1'b0;
    bus.rx_done = 1'b0;
    bus.rx_data = 8'h00;
    forever begin
      if (bus.transmit && !rst && plan.size() > 0) begin
        s        = plan.pop_front();
        drv_busy = 1'b1;
        c2       = cyc;
        if (s.rst_mid) begin
          #2 rst_drv = 1'b1;
          #1 check("reset_async", 64'({bus.tx_data, bus.transmit, bus.ram_addr, bus.dumping,
                                       bus.done, bus.timeout, bus.err_count}), 64'(0));
          @(negedge clk);
          rst_drv = 1'b0;
          for (int i = 0; i < 20; i++) begin
            bus.tx_done = i[0];
            bus.rx_done = ~i[0];
            bus.rx_data = 8'($urandom);
            @(negedge clk);
          end
          bus.tx_done = 1'b0;
          bus.rx_done = 1'b0;
          check("reset_idle", 64'({bus.tx_data, bus.transmit, bus.ram_addr, bus.dumping,
                                   bus.done, bus.timeout, bus.err_count}), 64'(0));
        end else begin
          r = s.silent ? -1 : s.lat + s.off;
          a = s.lat + ((s.off > 1) ? s.off : 1);
          n = s.lat;
          if (r > n) n = r;
          if (s.retrig && s.lat + 2 > n) n = s.lat + 2;
          if (s.silent)      exp_done_cyc.push_back(c2 + s.lat + TO);
          else if (s.last)   exp_done_cyc.push_back(c2 + a + 2);
          else if (s.retrig) exp_tx_cyc.push_back(c2 + s.lat + 4);
          else               exp_tx_cyc.push_back(c2 + a + 3);
          for (int i = 1; i <= n; i++) begin
            if (i > 1) @(negedge clk);
            if (s.retrig && i == s.lat + 3)
              check("retrig_state", 64'({bus.err_count, bus.ram_addr, bus.dumping, bus.done, bus.timeout}),
                    64'({16'h0, 16'h0, 3'b100}));
            bus.tx_done = (i == s.lat);
            bus.rx_done = (i == r);
            bus.rx_data = (i == r) ? s.echo : 8'($urandom);
            drv_trig    = s.retrig && (i == s.lat + 2);
          end
          @(negedge clk);
          bus.tx_done = 1'b0;
          bus.rx_done = 1'b0;
          drv_trig    = 1'b0;
        end
        drv_busy = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
  end

  // Reference model: one plan step per byte; the echo differs from RAM on bad bytes, which are counted.
  task automatic queue_dump(input int bad_kind, input int off_kind);
    int err = 0;
    for (int a = 0; a < NB; a++) begin
      step_t s;
      s = '{default: 0};
      s.lat = (off_kind == 0) ? 4 : int'($urandom_range(10, 3));
      if (off_kind == 0)                  s.off = 5;
      else if (off_kind == 2 && a == 0)   s.off = 0;
      else if (off_kind == 2 && a == 1)   s.off = -2;
      else                                s.off = int'($urandom_range(8, 0)) - 2;
      s.echo = mem[a];
      if (bad_kind == 1 && (a == 2 || a == 5)) s.echo = 8'hFF;
      if (bad_kind == 2 && $urandom_range(3, 0) == 0) s.echo = mem[a] ^ 8'($urandom_range(255, 1));
      if (s.echo != mem[a]) err++;
      s.last = (a == NB - 1);
      plan.push_back(s);
      exp_bytes.push_back(mem[a]);
    end
    exp_status.push_back('{err: 16'(err), tmo: 1'b0, addr: 16'(NB - 1)});
  endtask

  task automatic start_dump();
    exp_tx_cyc.push_back(cyc + 3);
    main_trig = 1'b1;
    @(negedge clk);
    main_trig = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int pend = 1;
    for (int k = 0; k < 4000; k++) begin
      pend = plan.size() + exp_bytes.size() + exp_status.size() + exp_done_cyc.size()
             + exp_tx_cyc.size() + int'(drv_busy);
      if (pend == 0) break;
      @(negedge clk);
    end
    check({"complete_", name}, 64'(pend), 64'(0));
    if (pend != 0) begin
      plan.delete();
      exp_bytes.delete();
      exp_status.delete();
      exp_done_cyc.delete();
      exp_tx_cyc.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic fill_random();
    for (int a = 0; a < NB; a++) mem[a] = 8'($urandom_range(255, 1));
  endtask

  initial begin
    int err;
    step_t s;

    #12;
    check("reset_values", 64'({bus.tx_data, bus.transmit, bus.ram_addr, bus.dumping,
                               bus.done, bus.timeout, bus.err_count}), 64'(0));
    @(negedge clk);
    rst_main = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_after_reset", 64'({bus.transmit, bus.dumping, bus.done, bus.err_count}), 64'(0));

    // Ascending RAM, clean echoes 5 clocks after tx_done.
    for (int a = 0; a < NB; a++) mem[a] = 8'h10 + 8'(a);
    queue_dump(0, 0);
    start_dump();
    wait_idle("clean");

    // Bytes 2 and 5 echoed as 0xFF.
    queue_dump(1, 0);
    start_dump();
    wait_idle("bad_echo");

    // Byte 0 echoed with tx_done, byte 1 two clocks before it.
    fill_random();
    queue_dump(0, 2);
    start_dump();
    wait_idle("early_echo");

    // Host goes silent after byte 3.
    fill_random();
    err = 0;
    for (int a = 0; a < 4; a++) begin
      s = '{default: 0};
      s.lat  = int'($urandom_range(10, 3));
      s.off  = int'($urandom_range(8, 0)) - 2;
      s.echo = mem[a];
      if (a < 3 && $urandom_range(3, 0) == 0) s.echo = mem[a] ^ 8'h3C;
      if (s.echo != mem[a]) err++;
      if (a == 3) begin
        s.silent = 1'b1;
        s.last   = 1'b1;
      end
      plan.push_back(s);
      exp_bytes.push_back(mem[a]);
    end
    exp_status.push_back('{err: 16'(err), tmo: 1'b1, addr: 16'd3});
    start_dump();
    wait_idle("timeout");
    repeat (80) @(negedge clk);

    // Restart while waiting for the echo of byte 4; its stale echo lands during the restart.
    fill_random();
    mem[4] = mem[0] ^ 8'h81;
    for (int a = 0; a < 5; a++) begin
      s = '{default: 0};
      s.lat  = int'($urandom_range(10, 3));
      s.off  = int'($urandom_range(8, 0)) - 2;
      s.echo = (a == 1) ? (mem[a] ^ 8'h5A) : mem[a];
      if (a == 4) begin
        s.off    = 4;
        s.retrig = 1'b1;
      end
      plan.push_back(s);
      exp_bytes.push_back(mem[a]);
    end
    queue_dump(2, 1);
    start_dump();
    wait_idle("retrigger");

    repeat (4) begin
      fill_random();
      queue_dump(2, 1);
      start_dump();
      wait_idle("random");
    end

    // Asynchronous reset while byte 2 is in flight, then stray UART pulses.
    fill_random();
    for (int a = 0; a < 3; a++) begin
      s = '{default: 0};
      s.lat     = int'($urandom_range(10, 3));
      s.off     = int'($urandom_range(8, 0)) - 2;
      s.echo    = mem[a];
      s.rst_mid = (a == 2);
      plan.push_back(s);
      exp_bytes.push_back(mem[a]);
    end
    start_dump();
    wait_idle("reset_mid");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_dump.md
# ram_dump

Read-back counterpart to the boot loader: on `trigger` it walks program RAM from address 0 to the top, sends each byte over the UART transmitter and waits for the host to echo it back. Echoes are compared against the sent byte, and mismatches are counted. The host can therefore verify a freshly loaded image, or dump RAM for debug, over the same serial link. The block sits between the UART rx/tx cores and the RAM read port, alongside the boot loader.

## Interface
- `ADDR_BITS`, 10: RAM address width; dump covers 0 .. 2**ADDR_BITS-1; legal range 1..16.
- `TIMEOUT_CYCLES`, 50_000_000: max clocks to wait for a host echo before aborting; must be ≥ 2.

- `clk`  in  1  system clock; one clock domain for the whole block.
- `rst`  in  1  asynchronous, active-high reset.
- `trigger`  in  1  start/restart dump; sampled each rising edge.
- `rx_data`  in  8  byte from UART receiver; valid when `rx_done`.
- `rx_done`  in  1  one-cycle pulse, receiver has a byte.
- `tx_done`  in  1  one-cycle pulse, transmitter finished a byte.
- `tx_data`  out  8  byte to transmit.
- `transmit`  out  1  one-cycle start pulse to UART transmitter.
- `ram_addr`  out  16  RAM read address; bits above `ADDR_BITS` are always 0.
- `ram_rdata`  in  8  RAM read data, valid one clock after `ram_addr` changes (synchronous RAM).
- `dumping`  out  1  high while a dump is in progress.
- `done`  out  1  high once a dump has finished (normally or by timeout), until next trigger.
- `timeout`  out  1  dump aborted waiting for an echo.
- `err_count`  out  16  echo mismatches this dump; saturates at 0xFFFF.

## Operation
- Reset values: `state` = S_IDLE; every output 0.
- `trigger` has priority in every state, including mid-dump. The same edge sets `ram_addr`=0, `err_count`=0, `dumping`=1, `done`=0, `timeout`=0, `transmit`=0, clears the early-ack flag and goes to S_READ.
- States:
  - S_IDLE: hold outputs and wait for `trigger`.
  - S_READ: wait one clock for RAM latency; → S_LATCH.
  - S_LATCH: `tx_data` <= `ram_rdata`, `transmit` <= 1; → S_WAIT_TX.
  - S_WAIT_TX: `transmit` <= 0. On `tx_done`, clear the timeout counter; → S_WAIT_ACK.
  - S_WAIT_ACK: on `rx_done` (or early-ack flag set), compare the echo with `tx_data`. On mismatch, `err_count` += 1 unless it is 0xFFFF. Clear the flag; → S_NEXT. Otherwise increment the timeout counter; when it reaches `TIMEOUT_CYCLES`-1 → S_DONE with `timeout`=1.
  - S_NEXT: if `ram_addr` == 2**ADDR_BITS-1 → S_DONE. Else `ram_addr` += 1; → S_READ.
  - S_DONE: `dumping`=0, `done`=1; stay until `trigger`.
- Early echo: `rx_done` during S_WAIT_TX (including the same cycle as `tx_done`) latches `rx_data` into an ack register and sets the early-ack flag. A second early `rx_done` overwrites the register. `rx_done` in S_IDLE, S_DONE, S_READ or S_LATCH is ignored.
- `rx_done` and `tx_done` in the same S_WAIT_TX cycle: the echo is captured and consumed in the first S_WAIT_ACK cycle.
- `tx_done` outside S_WAIT_TX is ignored.

## Timing
- Edge E0 samples `trigger`. E1: S_LATCH. E2: `transmit`=1 with `tx_data`=RAM[0]. E3: `transmit`=0.
- `transmit` is high for exactly one clock per byte. `tx_data` is stable from the `transmit` edge until the next S_LATCH.
- After the echo is accepted: S_NEXT takes 1 clock, and the next `transmit` pulse follows 3 clocks after S_WAIT_ACK exits (S_NEXT, S_READ, S_LATCH).
- Last byte: its echo is accepted in S_WAIT_ACK; 2 edges later `done`=1 and `dumping`=0.
- Timeout: `TIMEOUT_CYCLES` clocks in S_WAIT_ACK without an echo → next edge S_DONE. `ram_addr` holds the failing address.
- `rst` asserted at any time forces reset values immediately, without waiting for a clock edge.

## Test plan
- ADDR_BITS=3, RAM = 0x10..0x17, host model echoes each byte 5 clocks after `tx_done` → 8 `transmit` pulses carrying 0x10..0x17 in order; `done`=1, `err_count`=0, `timeout`=0; `ram_addr` ends at 7.
- Same setup, host echoes 0xFF for bytes 2 and 5 → `err_count`=2 at `done`; all 8 bytes still sent.
- Host echoes byte 0 in the same cycle as `tx_done`, and byte 1 two clocks before `tx_done` → both accepted, no mismatch, no timeout, dump completes.
- TIMEOUT_CYCLES=50, host silent after byte 3 → `timeout`=1, `done`=1, `dumping`=0, `ram_addr`=3, exactly 50 clocks after `tx_done` of byte 3; no further `transmit`.
- `trigger` while waiting for the echo of byte 4 → `err_count`=0, `ram_addr`=0, `transmit` with RAM[0] at E2; the stale echo arriving later is ignored; dump completes with 8 bytes.
- `rst` asserted mid-S_WAIT_TX, between clock edges → all outputs 0 immediately; with no `trigger` afterwards the block stays in S_IDLE and ignores `rx_done`/`tx_done`.
